// File: rtl/logic_gate_pkg.sv
// Shared types and the per-bit base operation
// for the registered logic unit.
package logic_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NAND,
    OP_NOR,
    OP_XNOR
  } op_e;

  typedef enum logic [1:0] {
    B_AND,
    B_OR,
    B_XOR
  } base_e;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_e;

  function automatic logic apply_base(
    base_e base,
    logic  x,
    logic  y
  );
    logic r;
    unique case (base)
      B_AND:   r = x & y;
      B_OR:    r = x | y;
      B_XOR:   r = x ^ y;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Valid/ready bundle for the logic unit:
// operand side in, result side out.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             acc_en;
  logic             in_last;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_err;

  modport master (
    output in_valid, op, acc_en, in_last,
    output a, b, out_ready,
    input  in_ready, out_valid, y, y_err
  );

  modport slave (
    input  in_valid, op, acc_en, in_last,
    input  a, b, out_ready,
    output in_ready, out_valid, y, y_err
  );
endinterface

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer; with
// SKID_EN=0 it degrades to a single register.
module skid_buf #(
  parameter int W       = 9,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   cnt;
  logic [1:0]   cnt_nxt;
  logic         rdy_q;
  logic         push;
  logic         pop;

  assign out_valid = (cnt != 2'd0);
  assign q         = e0;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & in_ready;
  assign cnt_nxt   = cnt + {1'b0, push}
                         - {1'b0, pop};

  // rdy_q also holds in_ready low through reset
  assign in_ready = SKID_EN ? rdy_q
                  : (rdy_q & ((cnt == 2'd0) | out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      rdy_q <= 1'b0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      cnt   <= cnt_nxt;
      rdy_q <= SKID_EN ? (cnt_nxt != 2'd2) : 1'b1;
      if (pop)
        e0 <= e1;
      if (push) begin
        if (cnt == 2'd1 && !pop)
          e1 <= d;
        else
          e0 <= d;
      end
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered two-operand logic unit with
// burst-accumulate mode and skid output.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  logic_gate_pipe_if.slave bus
);

  acc_state_e       state;
  logic [WIDTH-1:0] acc_q;
  base_e            base_q;
  logic             inv_q;
  logic             err_q;

  base_e            op_base;
  logic             op_inv;
  logic             op_err;

  logic             in_accum;
  base_e            base_sel;
  logic             inv_sel;
  logic             err_sel;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] acc_res;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;

  logic             skid_rdy;
  logic             accept;
  logic             emit;
  logic             skid_ov;
  logic [WIDTH:0]   skid_q;

  always_comb begin
    op_base = B_AND;
    op_inv  = 1'b0;
    op_err  = 1'b0;
    unique case (1'b1)
      (bus.op == OP_AND):  op_base = B_AND;
      (bus.op == OP_OR):   op_base = B_OR;
      (bus.op == OP_XOR):  op_base = B_XOR;
      (bus.op == OP_NAND): begin
        op_base = B_AND;
        op_inv  = 1'b1;
      end
      (bus.op == OP_NOR): begin
        op_base = B_OR;
        op_inv  = 1'b1;
      end
      (bus.op == OP_XNOR): begin
        op_base = B_XOR;
        op_inv  = 1'b1;
      end
      default: op_err = 1'b1;
    endcase
  end

  // Later beats of a burst follow the op latched on beat one
  assign in_accum = (state == ACCUM);
  assign base_sel = in_accum ? base_q : op_base;
  assign inv_sel  = in_accum ? inv_q  : op_inv;
  assign err_sel  = in_accum ? err_q  : op_err;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign p[i] = apply_base(base_sel,
                             bus.a[i], bus.b[i]);
    assign acc_res[i] = apply_base(base_sel,
                                   acc_q[i], p[i]);
  end

  assign raw = in_accum ? acc_res : p;
  assign res = err_sel ? '0
             : (inv_sel ? ~raw : raw);

  assign accept = bus.in_valid & skid_rdy;
  assign emit   = accept & (in_accum ? bus.in_last
                : (!bus.acc_en | bus.in_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc_q  <= '0;
      base_q <= B_AND;
      inv_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      if (in_accum) begin
        if (bus.in_last)
          state <= IDLE;
        else
          acc_q <= acc_res;
      end else if (bus.acc_en && !bus.in_last) begin
        state  <= ACCUM;
        acc_q  <= p;
        base_q <= op_base;
        inv_q  <= op_inv;
        err_q  <= op_err;
      end
    end
  end

  skid_buf #(
    .W       (WIDTH + 1),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (emit),
    .in_ready  (skid_rdy),
    .d         ({err_sel, res}),
    .out_valid (skid_ov),
    .out_ready (bus.out_ready),
    .q         (skid_q)
  );

  assign bus.in_ready  = skid_rdy;
  assign bus.out_valid = skid_ov;
  assign bus.y         = skid_q[WIDTH-1:0];
  assign bus.y_err     = skid_q[WIDTH];

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed testbench for logic_gate_pipe
// (WIDTH=8, SKID_EN=1).
module tb_logic_gate_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic_gate_pipe_if #(.WIDTH(8)) bus ();

  logic_gate_pipe #(
    .WIDTH   (8),
    .SKID_EN (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.acc_en    = 1'b0;
    bus.in_last   = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready got %b want 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.y !== 8'h00 || bus.y_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_y got %h/%b want 00/0", bus.y, bus.y_err);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rel_in_ready got %b want 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_and();
    bus.in_valid = 1'b1;
    bus.op       = 3'd0;
    bus.a        = 8'hF0;
    bus.b        = 8'h3C;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL and_pre_valid got %b want 0", bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'h30
        || bus.y_err !== 1'b0) begin
      errors++;
      $display("FAIL and_result got v=%b y=%h e=%b want 1/30/0",
               bus.out_valid, bus.y, bus.y_err);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL and_one_shot got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6];
    exp = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55};
    bus.a = 8'hA5;
    bus.b = 8'h0F;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.op = 3'(i);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got %b want 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== exp[i]) begin
        errors++;
        $display("FAIL b2b_y[%0d] got v=%b y=%h want 1/%h",
                 i, bus.out_valid, bus.y, exp[i]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    logic [7:0] av [3];
    logic [7:0] bv [3];
    av = '{8'h01, 8'h04, 8'h10};
    bv = '{8'h02, 8'h00, 8'h20};
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a       = av[i];
      bus.b       = bv[i];
      bus.op      = (i == 1) ? 3'd0 : 3'd4;
      bus.acc_en  = (i != 1);
      bus.in_last = (i == 2);
      tick();
      if (i < 2) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL burst_quiet[%0d] got %b want 0", i, bus.out_valid);
        end
      end
    end
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'hC8
        || bus.y_err !== 1'b0) begin
      errors++;
      $display("FAIL burst_nor got v=%b y=%h e=%b want 1/c8/0",
               bus.out_valid, bus.y, bus.y_err);
    end
    tick();
  endtask

  task automatic test_stall();
    int sent;
    int got;
    logic acc;
    logic pop;
    logic [7:0] yv;
    sent = 0;
    got  = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 3'd0;
    bus.a         = 8'h01;
    bus.b         = 8'hFF;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (c == 5) bus.out_ready = 1'b1;
      #1;
      acc = bus.in_valid & bus.in_ready;
      pop = bus.out_valid & bus.out_ready;
      yv  = bus.y;
      if (pop) begin
        checks++;
        if (yv !== 8'(got + 1)) begin
          errors++;
          $display("FAIL stall_order[%0d] got %h want %h",
                   got, yv, 8'(got + 1));
        end
        got++;
      end
      tick();
      if (acc) begin
        sent++;
        if (sent == 4) bus.in_valid = 1'b0;
        else bus.a = 8'(sent + 1);
      end
      if (c == 4) begin
        checks++;
        if (bus.in_ready !== 1'b0 || sent != 2) begin
          errors++;
          $display("FAIL stall_full got rdy=%b sent=%0d want 0/2",
                   bus.in_ready, sent);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.y !== 8'h01) begin
          errors++;
          $display("FAIL stall_hold got v=%b y=%h want 1/01",
                   bus.out_valid, bus.y);
        end
      end
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL stall_drain got %0d results want 4", got);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_illegal();
    bus.in_valid = 1'b1;
    bus.op       = 3'd7;
    bus.a        = 8'hFF;
    bus.b        = 8'hFF;
    tick();
    bus.op = 3'd0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'h00
        || bus.y_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal got v=%b y=%h e=%b want 1/00/1",
               bus.out_valid, bus.y, bus.y_err);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'hFF
        || bus.y_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got v=%b y=%h e=%b want 1/ff/0",
               bus.out_valid, bus.y, bus.y_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.in_valid = 1'b1;
    bus.op       = 3'd0;
    bus.acc_en   = 1'b1;
    bus.in_last  = 1'b0;
    bus.a        = 8'hFF;
    bus.b        = 8'h0F;
    tick();
    bus.a = 8'hF0;
    bus.b = 8'hFF;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0
        || bus.y !== 8'h00 || bus.y_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got r=%b v=%b y=%h e=%b want 0/0/00/0",
               bus.in_ready, bus.out_valid, bus.y, bus.y_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.op       = 3'd2;
    bus.acc_en   = 1'b1;
    bus.in_last  = 1'b1;
    bus.a        = 8'h0F;
    bus.b        = 8'hFF;
    tick();
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'hF0
        || bus.y_err !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_xor got v=%b y=%h e=%b want 1/f0/0",
               bus.out_valid, bus.y, bus.y_err);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_single got %b want 0", bus.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_and();
    test_back_to_back();
    test_burst();
    test_stall();
    test_illegal();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
